smix_scheduler: RTL and testbench
=================================

SMIX_SCHEDULER -- requirements
Module: smix_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one scrypt_smix core (range 2..8).
REQ-002 SHALL have parameter WATCHDOG_CYCLES, default 1048576, cycles allowed in WAIT before timeout (used only under REQ-026).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester job request.
REQ-006 SHALL have port req_data  input  NUM_REQ*1024  job block; requester i at bits [1024*i +: 1024].
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-hot accept; job transfers when req_valid[i] and req_ready[i] are both high.
REQ-008 SHALL have port core_enable  output  1  single-cycle start pulse to the core.
REQ-009 SHALL have port core_data  output  1024  block presented to the core.
REQ-010 SHALL have port core_hash  input  1024  core result.
REQ-011 SHALL have port core_done  input  1  core result-valid strobe.
REQ-012 SHALL have port rsp_valid  output  1  result available.
REQ-013 SHALL have port rsp_id  output  $clog2(NUM_REQ)  index of the requester that owns the result.
REQ-014 SHALL have port rsp_hash  output  1024  result block.
REQ-015 SHALL have port rsp_ready  input  1  consumer accept; result transfers when rsp_valid and rsp_ready are both high.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT, RESP.
REQ-018 IDLE: if any req_valid bit is high, req_ready SHALL assert combinationally for exactly one requester, the first valid index at or after rr_ptr (wrapping NUM_REQ-1 to 0); req_data of that requester and its index SHALL be registered, then go to LAUNCH.
REQ-019 req_ready SHALL be all-zero outside IDLE and in IDLE when req_valid is zero.
REQ-020 LAUNCH: core_enable SHALL be 1 for exactly this one cycle, then go to WAIT; core_data SHALL hold the registered block from LAUNCH until the next accept.
REQ-021 WAIT: on core_done, core_hash SHALL be registered into rsp_hash, then go to RESP; core_done in any other state SHALL be ignored.
REQ-022 RESP: rsp_valid SHALL be 1 and rsp_id/rsp_hash SHALL be stable until rsp_ready; on the transfer cycle go to IDLE and set rr_ptr to (granted index + 1) mod NUM_REQ.
REQ-023 Minimum latency SHALL be accept cycle (IDLE) -> core_enable on the next cycle -> rsp_valid on the cycle after core_done.
REQ-024 A requester dropping req_valid while not granted SHALL have no effect; only one job SHALL be in flight at a time.

Reset
REQ-025 While n_rst=0 at a rising clk edge: state=IDLE, rr_ptr=0, core_enable=0, rsp_valid=0, rsp_id=0, rsp_hash=0, core_data=0, busy=0 (including reset mid-job; the in-flight job is discarded and a later core_done is ignored).

Configuration
REQ-026 With macro SMIX_SCHED_WATCHDOG_EN defined: an extra output rsp_err (1 bit) SHALL exist; a counter SHALL clear on entering WAIT; if WATCHDOG_CYCLES cycles elapse in WAIT without core_done, go to RESP with rsp_hash=0 and rsp_err=1; rsp_err=0 on normal completion and after reset.
REQ-027 Without SMIX_SCHED_WATCHDOG_EN: there SHALL be no rsp_err port and no counter, and WAIT SHALL wait indefinitely.

Structure
REQ-028 Package smix_sched_pkg SHALL hold the state enum typedef and constant SMIX_BLOCK_W=1024.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs request vector and pointer; output one-hot grant plus index).

Verification
REQ-030 Single job: req_valid=4'b0001, req_data[0]=words 0..31 -> req_ready=4'b0001 that cycle, core_enable pulse next cycle with core_data=words 0..31; model core_done after 5 cycles with core_hash=~data -> rsp_valid, rsp_id=0, rsp_hash=~data.
REQ-031 Fairness: req_valid=4'b1111 held for 8 jobs -> grant order 0,1,2,3,0,1,2,3.
REQ-032 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_id/rsp_hash stable, req_ready=0, no core_enable; release -> IDLE next cycle.
REQ-033 Reset mid-job: n_rst=0 in WAIT, then core_done=1 after release -> no rsp_valid, busy=0, next grant to index 0.
REQ-034 Watchdog (macro on, WATCHDOG_CYCLES=16): no core_done -> rsp_valid after 16 WAIT cycles with rsp_err=1, rsp_hash=0; macro off -> stays in WAIT for 100 cycles.

Source files
------------

// File: rtl/smix_sched_pkg.sv
// Shared types and constants for the scrypt smix job scheduler.
package smix_sched_pkg;

  // Width of one scrypt block as seen by the smix core.
  localparam int SMIX_BLOCK_W = 1024;

  // Scheduler FSM: accept a job, start the core, wait for its result, hand it out.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } smix_state_e;

  // Successor of a requester index, wrapping at n.
  function automatic int next_index(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/smix_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index at or after ptr,
// wrapping from N-1 back to 0. Purely combinational.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  // slot_idx[k] is the requester index visited k-th when searching from ptr
  logic [IDX_W:0]   slot_sum [N];
  logic [IDX_W-1:0] slot_idx [N];
  logic [N-1:0]     rot_req;

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    assign slot_sum[gi] = {1'b0, ptr} + (IDX_W+1)'(gi);
    assign slot_idx[gi] = (slot_sum[gi] >= (IDX_W+1)'(N))
                          ? IDX_W'(slot_sum[gi] - (IDX_W+1)'(N))
                          : IDX_W'(slot_sum[gi]);
    assign rot_req[gi]  = req[slot_idx[gi]];
  end

  // Priority-pick the first requesting slot in search order
  always_comb begin
    logic found;
    found       = 1'b0;
    grant       = '0;
    grant_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot_req[k]) begin
        found               = 1'b1;
        grant_idx           = slot_idx[k];
        grant[slot_idx[k]]  = 1'b1;
      end
    end
    grant_valid = found;
  end

endmodule

// File: rtl/smix_scheduler.sv
// smix_scheduler: shares one scrypt_smix core between NUM_REQ requesters.
// One job in flight at a time; requesters served round-robin.
// Optional feature: define SMIX_SCHED_WATCHDOG_EN to add a WAIT-state
// timeout (WATCHDOG_CYCLES) that reports a zero result with rsp_err=1.
module smix_scheduler
  import smix_sched_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int WATCHDOG_CYCLES = 1048576
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*SMIX_BLOCK_W-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            core_enable,
  output logic [SMIX_BLOCK_W-1:0]         core_data,
  input  logic [SMIX_BLOCK_W-1:0]         core_hash,
  input  logic                            core_done,
  output logic                            rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
  output logic [SMIX_BLOCK_W-1:0]         rsp_hash,
  input  logic                            rsp_ready,
  output logic                            busy
`ifdef SMIX_SCHED_WATCHDOG_EN
  ,
  output logic                            rsp_err
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  smix_state_e             state_q,     state_d;
  logic [IDX_W-1:0]        rr_ptr_q,    rr_ptr_d;
  logic [IDX_W-1:0]        grant_id_q,  grant_id_d;
  logic [SMIX_BLOCK_W-1:0] core_data_q, core_data_d;
  logic [SMIX_BLOCK_W-1:0] rsp_hash_q,  rsp_hash_d;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_valid;
  logic [SMIX_BLOCK_W-1:0] req_blk [NUM_REQ];
  logic                    wd_expired;

  // Split the flat request bus into one block per requester
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_blk
    assign req_blk[gi] = req_data[gi*SMIX_BLOCK_W +: SMIX_BLOCK_W];
  end

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr_q),
    .grant       (arb_grant),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

`ifdef SMIX_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            rsp_err_q, rsp_err_d;

  assign wd_expired = (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1));
  assign rsp_err    = rsp_err_q;

  // Watchdog: restart count on the way into WAIT, flag timeout vs normal finish
  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    rsp_err_d = rsp_err_q;
    if (state_q == LAUNCH) begin
      wd_cnt_d = '0;
    end else if (state_q == WAIT) begin
      if (core_done) begin
        rsp_err_d = 1'b0;
      end else if (wd_expired) begin
        rsp_err_d = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
      end
    end
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wd_cnt_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end
`else
  // Without the watchdog WAIT never times out; the parameter is inert here.
  logic wd_param_unused;
  assign wd_param_unused = (WATCHDOG_CYCLES > 0);
  assign wd_expired      = 1'b0;
`endif

  // Next-state logic: accept in IDLE, pulse core in LAUNCH, capture result in WAIT
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    core_data_d = core_data_q;
    rsp_hash_d  = rsp_hash_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        req_ready = arb_grant;
        if (arb_valid) begin
          grant_id_d  = arb_idx;
          core_data_d = req_blk[arb_idx];
          state_d     = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          rsp_hash_d = core_hash;
          state_d    = RESP;
        end else if (wd_expired) begin
          rsp_hash_d = '0;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          // Next search starts just past the requester that was served
          rr_ptr_d = IDX_W'(next_index(int'(grant_id_q), NUM_REQ));
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight job
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      core_data_q <= '0;
      rsp_hash_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      core_data_q <= core_data_d;
      rsp_hash_q  <= rsp_hash_d;
    end
  end

  assign core_enable = (state_q == LAUNCH);
  assign core_data   = core_data_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = grant_id_q;
  assign rsp_hash    = rsp_hash_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_smix_scheduler.sv
// Self-checking bench for smix_scheduler with a behavioural round-robin model
// and a simple core model answering with core_hash = ~core_data.
module tb_smix_scheduler;

  localparam int N  = 4;
  localparam int W  = 1024;
  localparam int IW = 2;
  localparam int WD = 16;

  logic           clk = 1'b0;
  logic           n_rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           core_enable;
  logic [W-1:0]   core_data;
  logic [W-1:0]   core_hash;
  logic           core_done;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_hash;
  logic           rsp_ready;
  logic           busy;
`ifdef SMIX_SCHED_WATCHDOG_EN
  logic           rsp_err;
`endif

  always #5 clk = ~clk;

  smix_scheduler #(
    .NUM_REQ         (N),
    .WATCHDOG_CYCLES (WD)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .core_enable (core_enable),
    .core_data   (core_data),
    .core_hash   (core_hash),
    .core_done   (core_done),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_hash    (rsp_hash),
    .rsp_ready   (rsp_ready),
    .busy        (busy)
`ifdef SMIX_SCHED_WATCHDOG_EN
    ,
    .rsp_err     (rsp_err)
`endif
  );

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;      // model round-robin pointer
  int job_no = 0;
  logic [W-1:0] blk [N];

  // observations of the last job run by do_job
  logic [N-1:0]  o_ready;
  logic          o_en_launch;
  logic [W-1:0]  o_cdata;
  int            o_extra_en;
  int            o_early_rsp;
  logic          o_rv;
  logic [IW-1:0] o_id;
  logic [W-1:0]  o_hash;
  int            o_unstable;
  logic          o_busy_after;
  logic          o_rv_after;
  logic          o_err;

  // Reference: first requesting index at or after ptr, wrapping
  function automatic int exp_grant(input logic [N-1:0] m, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (m[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_block();
    logic [W-1:0] b;
    for (int w = 0; w < W/32; w++) b[32*w +: 32] = $urandom;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one complete job and records what the DUT did; no judging here.
  task automatic do_job(input logic [N-1:0] vmask, input int delay,
                        input int hold, input bit ramp);
    for (int i = 0; i < N; i++) begin
      if (ramp) begin
        for (int w = 0; w < W/32; w++) blk[i][32*w +: 32] = w;
      end else begin
        blk[i] = rand_block();
      end
      req_data[W*i +: W] = blk[i];
    end
    req_valid = vmask;
    rsp_ready = 1'b0;
    core_done = 1'b0;
    o_extra_en = 0;
    o_early_rsp = 0;
    o_unstable = 0;
    #1;
    o_ready = req_ready;
    tick();                                   // LAUNCH
    o_en_launch = core_enable;
    o_cdata     = core_data;
    if (req_ready !== '0) o_unstable++;
    tick();                                   // first WAIT cycle
    for (int c = 0; c < delay; c++) begin
      if (core_enable !== 1'b0) o_extra_en++;
      if (rsp_valid !== 1'b0) o_early_rsp++;
      tick();
    end
    if (core_enable !== 1'b0) o_extra_en++;
    if (rsp_valid !== 1'b0) o_early_rsp++;
    core_hash = ~o_cdata;
    core_done = 1'b1;
    tick();                                   // RESP expected
    core_done = 1'b0;
    core_hash = rand_block();
    o_rv   = rsp_valid;
    o_id   = rsp_id;
    o_hash = rsp_hash;
`ifdef SMIX_SCHED_WATCHDOG_EN
    o_err  = rsp_err;
`else
    o_err  = 1'b0;
`endif
    for (int c = 0; c < hold; c++) begin
      tick();
      core_hash = rand_block();
      if (rsp_valid !== 1'b1 || rsp_id !== o_id || rsp_hash !== o_hash ||
          req_ready !== '0 || core_enable !== 1'b0) o_unstable++;
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    o_busy_after = busy;
    o_rv_after   = rsp_valid;
    req_valid    = '0;
    job_no++;
    $display("job %0d: mask=%b grant_id=%0d hold=%0d delay=%0d", job_no, vmask, o_id, hold, delay);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; req_valid = '0; req_data = '0; core_hash = '0;
    core_done = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (core_enable !== 1'b0) begin errors++; $display("FAIL reset_core_enable: got %b want 0", core_enable); end
    checks++; if (core_data !== '0) begin errors++; $display("FAIL reset_core_data: got %h want 0", core_data[63:0]); end
    checks++; if (rsp_hash !== '0) begin errors++; $display("FAIL reset_rsp_hash: got %h want 0", rsp_hash[63:0]); end
    checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_rst = 1'b1;
    m_ptr = 0;
    // stray core_done in IDLE must be ignored
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL idle_done_ignored: got busy=%b rsp_valid=%b want 0/0", busy, rsp_valid);
    end
  endtask

  task automatic test_fairness();
    int g;
    for (int j = 0; j < 8; j++) begin
      g = exp_grant(4'b1111, m_ptr);
      do_job(4'b1111, $urandom_range(0, 3), 0, 1'b0);
      checks++; if (o_ready !== (4'b0001 << g)) begin errors++; $display("FAIL fair_ready job%0d: got %b want %b", j, o_ready, 4'b0001 << g); end
      checks++; if (o_id !== IW'(g)) begin errors++; $display("FAIL fair_id job%0d: got %0d want %0d", j, o_id, g); end
      checks++; if (o_hash !== ~blk[g]) begin errors++; $display("FAIL fair_hash job%0d: got %h want %h", j, o_hash[63:0], ~blk[g][63:0]); end
      m_ptr = (g + 1) % N;
    end
  endtask

  task automatic test_single_job();
    int g;
    g = exp_grant(4'b0001, m_ptr);
    do_job(4'b0001, 5, 0, 1'b1);
    checks++; if (o_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", o_ready); end
    checks++; if (o_en_launch !== 1'b1) begin errors++; $display("FAIL single_enable: got %b want 1", o_en_launch); end
    checks++; if (o_cdata !== blk[0]) begin errors++; $display("FAIL single_core_data: got %h want %h", o_cdata[63:0], blk[0][63:0]); end
    checks++; if (o_extra_en !== 0 || o_early_rsp !== 0) begin errors++; $display("FAIL single_wait: got extra_en=%0d early_rsp=%0d want 0/0", o_extra_en, o_early_rsp); end
    checks++; if (o_rv !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b want 1", o_rv); end
    checks++; if (o_id !== IW'(g)) begin errors++; $display("FAIL single_rsp_id: got %0d want %0d", o_id, g); end
    checks++; if (o_hash !== ~blk[0]) begin errors++; $display("FAIL single_rsp_hash: got %h want %h", o_hash[63:0], ~blk[0][63:0]); end
    checks++; if (o_busy_after !== 1'b0 || o_rv_after !== 1'b0) begin errors++; $display("FAIL single_idle_after: got busy=%b rsp_valid=%b want 0/0", o_busy_after, o_rv_after); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", o_err); end
    m_ptr = (g + 1) % N;
  endtask

  task automatic test_random_jobs();
    int g;
    logic [N-1:0] m;
    for (int j = 0; j < 20; j++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      g = exp_grant(m, m_ptr);
      do_job(m, $urandom_range(0, 6), $urandom_range(0, 3), 1'b0);
      checks++; if (o_ready !== (4'b0001 << g)) begin errors++; $display("FAIL rand_ready job%0d: got %b want %b", j, o_ready, 4'b0001 << g); end
      checks++; if (o_cdata !== blk[g] || o_en_launch !== 1'b1) begin errors++; $display("FAIL rand_launch job%0d: got en=%b data=%h want 1/%h", j, o_en_launch, o_cdata[63:0], blk[g][63:0]); end
      checks++; if (o_rv !== 1'b1 || o_id !== IW'(g) || o_hash !== ~blk[g]) begin errors++; $display("FAIL rand_rsp job%0d: got v=%b id=%0d h=%h want 1/%0d/%h", j, o_rv, o_id, o_hash[63:0], g, ~blk[g][63:0]); end
      checks++; if (o_unstable !== 0 || o_extra_en !== 0 || o_early_rsp !== 0) begin errors++; $display("FAIL rand_timing job%0d: got unstable=%0d extra_en=%0d early=%0d want 0", j, o_unstable, o_extra_en, o_early_rsp); end
      m_ptr = (g + 1) % N;
    end
  endtask

  task automatic test_backpressure();
    int g;
    g = exp_grant(4'b1111, m_ptr);
    do_job(4'b1111, 2, 10, 1'b0);
    checks++; if (o_rv !== 1'b1 || o_id !== IW'(g)) begin errors++; $display("FAIL bp_rsp: got v=%b id=%0d want 1/%0d", o_rv, o_id, g); end
    checks++; if (o_unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", o_unstable); end
    checks++; if (o_busy_after !== 1'b0) begin errors++; $display("FAIL bp_release: got busy=%b want 0", o_busy_after); end
    m_ptr = (g + 1) % N;
  endtask

  task automatic test_reset_mid_job();
    int g;
    g = exp_grant(4'b0100, m_ptr);
    do_job(4'b0100, 1, 0, 1'b0);              // leaves pointer at 3
    m_ptr = (g + 1) % N;
    req_valid = 4'b0010;
    tick();                                   // LAUNCH
    req_valid = '0;
    tick();                                   // WAIT
    n_rst = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || core_enable !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got busy=%b v=%b en=%b want 0", busy, rsp_valid, core_enable); end
    checks++; if (core_data !== '0 || rsp_hash !== '0 || rsp_id !== '0) begin errors++; $display("FAIL midrst_data: got cd=%h h=%h id=%0d want 0", core_data[63:0], rsp_hash[63:0], rsp_id); end
    n_rst = 1'b1;
    core_hash = rand_block();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_done_ignored: got v=%b busy=%b want 0/0", rsp_valid, busy); end
    m_ptr = 0;
    g = exp_grant(4'b1111, m_ptr);
    do_job(4'b1111, 0, 0, 1'b0);
    checks++; if (o_id !== IW'(g) || o_ready !== (4'b0001 << g)) begin errors++; $display("FAIL midrst_next_grant: got id=%0d ready=%b want %0d", o_id, o_ready, g); end
    m_ptr = (g + 1) % N;
  endtask

  task automatic test_watchdog();
    int g;
    int k;
    g = exp_grant(4'b0001, m_ptr);
    req_valid = 4'b0001;
    tick();                                   // LAUNCH
    req_valid = '0;
    tick();                                   // first WAIT cycle
`ifdef SMIX_SCHED_WATCHDOG_EN
    k = 0;
    while (rsp_valid !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    checks++; if (k !== WD) begin errors++; $display("FAIL wd_latency: got %0d cycles want %0d", k, WD); end
    checks++; if (rsp_err !== 1'b1 || rsp_hash !== '0 || rsp_id !== IW'(g)) begin errors++; $display("FAIL wd_rsp: got err=%b h=%h id=%0d want 1/0/%0d", rsp_err, rsp_hash[63:0], rsp_id, g); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    m_ptr = (g + 1) % N;
    g = exp_grant(4'b0011, m_ptr);
    do_job(4'b0011, 3, 0, 1'b0);
    checks++; if (o_err !== 1'b0 || o_hash !== ~blk[g]) begin errors++; $display("FAIL wd_normal: got err=%b h=%h want 0/%h", o_err, o_hash[63:0], ~blk[g][63:0]); end
    m_ptr = (g + 1) % N;
`else
    k = 0;
    for (int c = 0; c < 100; c++) begin
      if (rsp_valid !== 1'b0 || busy !== 1'b1) k++;
      tick();
    end
    checks++; if (k !== 0) begin errors++; $display("FAIL wait_forever: got %0d cycles leaving WAIT want 0", k); end
    n_rst = 1'b0;
    tick(); tick();
    n_rst = 1'b1;
    m_ptr = 0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_recover: got busy=%b want 0", busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_job();
    test_random_jobs();
    test_backpressure();
    test_reset_mid_job();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "bench timeout");
  end

endmodule
